// File: rtl/jtag_tap_controller_if.sv
// Signal bundle between a JTAG TAP controller and the logic around it.
// The slave modport is the TAP side; the master modport is the host or test side.
interface jtag_tap_controller_if;
    logic       TMS;
    logic       ir_tdo;
    logic       dr_tdo;
    logic [3:0] tap_state;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic       capture_ir;
    logic       shift_ir;
    logic       update_ir;
    logic       tlr;
    logic       TDO;
    logic       TDO_EN;

    modport slave (
        input  TMS, ir_tdo, dr_tdo,
        output tap_state, capture_dr, shift_dr, update_dr,
               capture_ir, shift_ir, update_ir, tlr, TDO, TDO_EN
    );

    modport master (
        output TMS, ir_tdo, dr_tdo,
        input  tap_state, capture_dr, shift_dr, update_dr,
               capture_ir, shift_ir, update_ir, tlr, TDO, TDO_EN
    );
endinterface

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM on rising TCK, state decodes,
// and a falling-edge TDO / TDO_EN output stage.
module jtag_tap_controller #(
    parameter logic [3:0] S_TLR        = 4'd0,
    parameter logic [3:0] S_RUN_IDLE   = 4'd1,
    parameter logic [3:0] S_SELECT_DR  = 4'd2,
    parameter logic [3:0] S_CAPTURE_DR = 4'd3,
    parameter logic [3:0] S_SHIFT_DR   = 4'd4,
    parameter logic [3:0] S_EXIT1_DR   = 4'd5,
    parameter logic [3:0] S_PAUSE_DR   = 4'd6,
    parameter logic [3:0] S_EXIT2_DR   = 4'd7,
    parameter logic [3:0] S_UPDATE_DR  = 4'd8,
    parameter logic [3:0] S_SELECT_IR  = 4'd9,
    parameter logic [3:0] S_CAPTURE_IR = 4'd10,
    parameter logic [3:0] S_SHIFT_IR   = 4'd11,
    parameter logic [3:0] S_EXIT1_IR   = 4'd12,
    parameter logic [3:0] S_PAUSE_IR   = 4'd13,
    parameter logic [3:0] S_EXIT2_IR   = 4'd14,
    parameter logic [3:0] S_UPDATE_IR  = 4'd15
) (
    input  logic                         TCK,
    input  logic                         TRST_N,
    jtag_tap_controller_if.slave         jtag
);

    typedef enum logic [3:0] {
        ST_TLR        = S_TLR,
        ST_RUN_IDLE   = S_RUN_IDLE,
        ST_SELECT_DR  = S_SELECT_DR,
        ST_CAPTURE_DR = S_CAPTURE_DR,
        ST_SHIFT_DR   = S_SHIFT_DR,
        ST_EXIT1_DR   = S_EXIT1_DR,
        ST_PAUSE_DR   = S_PAUSE_DR,
        ST_EXIT2_DR   = S_EXIT2_DR,
        ST_UPDATE_DR  = S_UPDATE_DR,
        ST_SELECT_IR  = S_SELECT_IR,
        ST_CAPTURE_IR = S_CAPTURE_IR,
        ST_SHIFT_IR   = S_SHIFT_IR,
        ST_EXIT1_IR   = S_EXIT1_IR,
        ST_PAUSE_IR   = S_PAUSE_IR,
        ST_EXIT2_IR   = S_EXIT2_IR,
        ST_UPDATE_IR  = S_UPDATE_IR
    } state_t;

    state_t state;
    state_t state_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) state <= ST_TLR;
        else         state <= state_next;
    end

    // NOTE: the default is assigned first so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_TLR:        state_next = jtag.TMS ? ST_TLR       : ST_RUN_IDLE;
            ST_RUN_IDLE:   state_next = jtag.TMS ? ST_SELECT_DR : ST_RUN_IDLE;
            ST_SELECT_DR:  state_next = jtag.TMS ? ST_SELECT_IR : ST_CAPTURE_DR;
            ST_CAPTURE_DR: state_next = jtag.TMS ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_SHIFT_DR:   state_next = jtag.TMS ? ST_EXIT1_DR  : ST_SHIFT_DR;
            ST_EXIT1_DR:   state_next = jtag.TMS ? ST_UPDATE_DR : ST_PAUSE_DR;
            ST_PAUSE_DR:   state_next = jtag.TMS ? ST_EXIT2_DR  : ST_PAUSE_DR;
            ST_EXIT2_DR:   state_next = jtag.TMS ? ST_UPDATE_DR : ST_SHIFT_DR;
            ST_UPDATE_DR:  state_next = jtag.TMS ? ST_SELECT_DR : ST_RUN_IDLE;
            ST_SELECT_IR:  state_next = jtag.TMS ? ST_TLR       : ST_CAPTURE_IR;
            ST_CAPTURE_IR: state_next = jtag.TMS ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_SHIFT_IR:   state_next = jtag.TMS ? ST_EXIT1_IR  : ST_SHIFT_IR;
            ST_EXIT1_IR:   state_next = jtag.TMS ? ST_UPDATE_IR : ST_PAUSE_IR;
            ST_PAUSE_IR:   state_next = jtag.TMS ? ST_EXIT2_IR  : ST_PAUSE_IR;
            ST_EXIT2_IR:   state_next = jtag.TMS ? ST_UPDATE_IR : ST_SHIFT_IR;
            ST_UPDATE_IR:  state_next = jtag.TMS ? ST_SELECT_DR : ST_RUN_IDLE;
            default:       state_next = ST_TLR;
        endcase
    end

    // Decodes look only at the state register, so each is stable for a whole TCK period.
    assign jtag.tap_state  = state;
    assign jtag.tlr        = (state == ST_TLR);
    assign jtag.capture_dr = (state == ST_CAPTURE_DR);
    assign jtag.shift_dr   = (state == ST_SHIFT_DR);
    assign jtag.update_dr  = (state == ST_UPDATE_DR);
    assign jtag.capture_ir = (state == ST_CAPTURE_IR);
    assign jtag.shift_ir   = (state == ST_SHIFT_IR);
    assign jtag.update_ir  = (state == ST_UPDATE_IR);

    // Falling-edge stage gives downstream logic half a period of setup before the next capture.
    // TDO keeps its last value outside the shift states.
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            jtag.TDO    <= 1'b0;
            jtag.TDO_EN <= 1'b0;
        end else begin
            jtag.TDO_EN <= (state == ST_SHIFT_DR) || (state == ST_SHIFT_IR);
            if (state == ST_SHIFT_IR)      jtag.TDO <= jtag.ir_tdo;
            else if (state == ST_SHIFT_DR) jtag.TDO <= jtag.dr_tdo;
        end
    end

endmodule

// File: doc/jtag_tap_controller.md
JTAG_TAP_CONTROLLER -- requirements
Module: jtag_tap_controller

Interface
REQ-001 Parameters S_TLR..S_UPDATE_IR SHALL default to 0..15 in this order: TLR, RUN_IDLE, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR.
REQ-002 TCK  input  1  test clock; all state updates on rising edge; TDO stage on falling edge.
REQ-003 TRST_N  input  1  reset, asynchronous, active-low.
REQ-004 TMS  input  1  test mode select, sampled on rising TCK.
REQ-005 ir_tdo  input  1  serial output of the instruction register shift stage.
REQ-006 dr_tdo  input  1  serial output of the currently selected data register.
REQ-007 tap_state  output  4  current TAP state, encoded per REQ-001.
REQ-008 capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir  output  1 each  state decodes, each high while tap_state equals the matching state.
REQ-009 tlr  output  1  high while in TLR; drives the synchronous reset of downstream registers.
REQ-010 TDO  output  1  registered serial output.
REQ-011 TDO_EN  output  1  output-enable for the TDO pad, active high.

Function
REQ-012 The state register SHALL advance once per rising TCK using the IEEE 1149.1 16-state graph, with next state a pure function of current state and TMS.
REQ-013 Transitions with TMS=1: TLR->TLR, RUN_IDLE->SELECT_DR, SELECT_DR->SELECT_IR, SELECT_IR->TLR, CAPTURE_x->EXIT1_x, SHIFT_x->EXIT1_x, EXIT1_x->UPDATE_x, PAUSE_x->EXIT2_x, EXIT2_x->UPDATE_x, UPDATE_x->SELECT_DR.
REQ-014 Transitions with TMS=0: TLR->RUN_IDLE, RUN_IDLE->RUN_IDLE, SELECT_DR->CAPTURE_DR, SELECT_IR->CAPTURE_IR, CAPTURE_x->SHIFT_x, SHIFT_x->SHIFT_x, EXIT1_x->PAUSE_x, PAUSE_x->PAUSE_x, EXIT2_x->SHIFT_x, UPDATE_x->RUN_IDLE.
REQ-015 Five consecutive rising TCK edges with TMS=1 SHALL reach TLR from any state.
REQ-016 Decode outputs (REQ-008, REQ-009) SHALL be combinational from the state register only, never from TMS, so downstream stages see them for exactly one full TCK period per state visit.
REQ-017 TDO source SHALL be ir_tdo when tap_state=SHIFT_IR and dr_tdo when tap_state=SHIFT_DR.
REQ-018 TDO and TDO_EN SHALL be registered on the falling edge of TCK.
REQ-019 TDO_EN SHALL be 1 after the falling edge of every TCK period whose state is SHIFT_DR or SHIFT_IR, and 0 after the falling edge of every other period.
REQ-020 When TDO_EN is 0, TDO SHALL hold its last value.
REQ-021 State-to-TDO latency: the first shifted bit SHALL appear on TDO half a TCK period after entering SHIFT_x; the pin is disabled half a period after leaving SHIFT_x.
REQ-022 The 4-bit encoding is fully used; no illegal states exist, and no recovery logic is required.

Reset
REQ-023 TRST_N low SHALL force tap_state=TLR (0) immediately and asynchronously, independent of TCK.
REQ-024 During reset: tlr=1, all other decodes 0, TDO=0, TDO_EN=0.
REQ-025 Reset asserted mid-shift SHALL abort the shift with no UPDATE_x pulse generated.
REQ-026 After TRST_N release, the first rising TCK SHALL apply REQ-013/REQ-014 from TLR.

Verification
REQ-027 Reset then TMS=0 for 1 TCK -> tap_state=1 (RUN_IDLE), tlr=0.
REQ-028 From RUN_IDLE, TMS sequence 1,1,0,0 -> states 2,9,10,11; capture_ir high for exactly one cycle; TDO_EN=1 from the falling edge in state 11.
REQ-029 In SHIFT_IR, drive ir_tdo pattern 1,0,1,1 then TMS 1,1 -> TDO shows 1,0,1,1 on successive falling edges; states 12 then 15; update_ir one cycle; TDO_EN drops in state 12.
REQ-030 From each of the 16 states, TMS=1 for 5 TCK -> tap_state=0.
REQ-031 From SHIFT_DR with TMS sequence 1,0,1,0 -> states 5,6,7,4; TDO_EN is 0 during PAUSE_DR and 1 again in SHIFT_DR.
REQ-032 Assert TRST_N low mid SHIFT_DR between clock edges -> tap_state=0 and TDO_EN=0 with no TCK edge, and update_dr is never asserted.
